// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants and helpers for the VGA raster scan engine.
//   - DEF_* localparams: 640x480@60 timing (pixels / lines).
//   - COLOUR_BLACK / COLOUR_WHITE: 8-bit colour constants.
//   - cnt_t: 16-bit unsigned scan counter type.
//   - h_total() / v_total(): line / frame lengths from the four timing
//     segments, evaluated at elaboration time.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    // 640x480@60 timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [7:0] COLOUR_BLACK = 8'h00;
    localparam logic [7:0] COLOUR_WHITE = 8'hFF;

    // Pixels per line, blanking included.
    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame, blanking included.
    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_axis.sv
// ----------------------------------------------------------------------------
// vga_sync_axis
//   One scan axis (horizontal or vertical): a counter that advances on en and
//   wraps TOTAL-1 -> 0, plus decode of the active region, the sync window and
//   one programmable marker position.
// Ports
//   clk      in   1   clock
//   rst_n    in   1   asynchronous active-low reset, counter -> 0
//   en       in   1   advance the counter this clk
//   cnt      out  16  current position
//   active   out  1   cnt < ACTIVE
//   in_sync  out  1   cnt inside [ACTIVE+FP, ACTIVE+FP+SYNC-1]
//   mark_hit out  1   en && cnt == MARK_AT (one-clk strobe)
// ----------------------------------------------------------------------------
module vga_sync_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE  = DEF_H_ACTIVE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP,
    parameter int MARK_AT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output cnt_t cnt,
    output logic active,
    output logic in_sync,
    output logic mark_hit
);

    localparam int   TOTAL      = h_total(ACTIVE, FP, SYNC, BP);
    localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
    localparam cnt_t ACTIVE_END = cnt_t'(ACTIVE);
    localparam cnt_t SYNC_START = cnt_t'(ACTIVE + FP);
    localparam cnt_t SYNC_END   = cnt_t'(ACTIVE + FP + SYNC);   // exclusive
    localparam cnt_t MARK       = cnt_t'(MARK_AT);

    logic at_last;

    assign at_last  = (cnt == LAST);
    assign active   = (cnt < ACTIVE_END);
    assign in_sync  = (cnt >= SYNC_START) && (cnt < SYNC_END);
    assign mark_hit = en && (cnt == MARK);

    // NOTE: the reset branch clears state asynchronously; every flop here has
    // a defined reset value so the scan always restarts at coordinate 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_controller.sv
// ----------------------------------------------------------------------------
// vga_scan_controller
//   Raster scan engine. Presents scan coordinates to a combinational pixel
//   generator, samples the returned colour one pixel tick later and drives the
//   VGA pins with rgb aligned to the (equally delayed) syncs. Emits a one-clk
//   frameTick as the last visible line ends, so game state can update during
//   vertical blanking.
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   pixelIn    in   8   colour for the current nextX/nextY
//   nextX      out  16  scan column (0..H_TOTAL-1)
//   nextY      out  16  scan row (0..V_TOTAL-1)
//   rgb        out  8   registered pixel, black outside the active area
//   hsync_n    out  1   registered horizontal sync, active low
//   vsync_n    out  1   registered vertical sync, active low
//   de         out  1   rgb carries a visible pixel
//   frameTick  out  1   one-clk pulse at entry to vertical blanking
// ----------------------------------------------------------------------------
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int PIXEL_DIV = 2,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pixelIn,
    output logic [15:0] nextX,
    output logic [15:0] nextY,
    output logic [7:0]  rgb,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic        frameTick
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

    // A single-bit divider still works for PIXEL_DIV=1: it stays at 0, which
    // equals DIV_LAST, so every clk is a pixel tick.
    localparam int                DIV_W    = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIXEL_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_active;
    logic v_active;
    logic h_in_sync;
    logic v_in_sync;
    logic h_wrap;       // tick on the last pixel of a line
    logic frame_end;    // h_wrap on the last visible line
    logic active1;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so each flop sees
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Horizontal axis: its marker is the last pixel of the line, which both
    // wraps the column and steps the row.
    vga_sync_axis #(
        .ACTIVE  (H_ACTIVE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .MARK_AT (H_TOTAL - 1)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tick),
        .cnt      (h_cnt),
        .active   (h_active),
        .in_sync  (h_in_sync),
        .mark_hit (h_wrap)
    );

    // Vertical axis: steps once per line; its marker is the last visible
    // line, so mark_hit fires exactly once per frame as that line ends.
    vga_sync_axis #(
        .ACTIVE  (V_ACTIVE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .MARK_AT (V_ACTIVE - 1)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (h_wrap),
        .cnt      (v_cnt),
        .active   (v_active),
        .in_sync  (v_in_sync),
        .mark_hit (frame_end)
    );

    assign nextX   = h_cnt;
    assign nextY   = v_cnt;
    assign active1 = h_active && v_active;

    // Stage 2: colour and syncs share one register stage, so they stay
    // aligned pixel for pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb     <= COLOUR_BLACK;
            de      <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (tick) begin
            rgb     <= active1 ? pixelIn : COLOUR_BLACK;
            de      <= active1;
            hsync_n <= ~h_in_sync;
            vsync_n <= ~v_in_sync;
        end
    end

    // Loaded every clk so the pulse lasts one clk regardless of PIXEL_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameTick <= 1'b0;
        end else begin
            frameTick <= frame_end;
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_vga_scan_controller
//   Drives a tiny-timing instance (H=4/1/2/1, V=3/1/1/1, PIXEL_DIV=2) against
//   a reference model that derives every output from the number of clks since
//   reset release, and a default-timing PIXEL_DIV=1 instance checked for line
//   period and visible width.
// ----------------------------------------------------------------------------
module tb_vga_scan_controller;

    localparam int PD  = 2;
    localparam int HA  = 4, HFP = 1, HS = 2, HBP = 1;
    localparam int VA  = 3, VFP = 1, VS = 1, VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;     // 8
    localparam int VT  = VA + VFP + VS + VBP;     // 6
    localparam int FT  = HT * VT;                 // pixels per frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_s = 8'h00;
    logic [7:0]  pix_l = 8'h5A;

    logic [15:0] nx_s, ny_s, nx_l, ny_l;
    logic [7:0]  rgb_s, rgb_l;
    logic        hs_s, vs_s, de_s, ft_s;
    logic        hs_l, vs_l, de_l, ft_l;
    logic [43:0] obs_s;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int          m_clks;
    logic [7:0]  m_rgb;
    logic        m_de, m_hs, m_vs, m_ft;

    always #5 clk = ~clk;

    vga_scan_controller #(
        .PIXEL_DIV (PD),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
    ) dut_s (
        .clk (clk), .rst_n (rst_n), .pixelIn (pix_s),
        .nextX (nx_s), .nextY (ny_s), .rgb (rgb_s),
        .hsync_n (hs_s), .vsync_n (vs_s), .de (de_s), .frameTick (ft_s)
    );

    vga_scan_controller #(
        .PIXEL_DIV (1)
    ) dut_l (
        .clk (clk), .rst_n (rst_n), .pixelIn (pix_l),
        .nextX (nx_l), .nextY (ny_l), .rgb (rgb_l),
        .hsync_n (hs_l), .vsync_n (vs_l), .de (de_l), .frameTick (ft_l)
    );

    assign obs_s = {nx_s, ny_s, rgb_s, hs_s, vs_s, de_s, ft_s};

    // ---------------- reference model ----------------
    function automatic int cur_pos();
        return (m_clks / PD) % FT;
    endfunction

    function automatic logic [43:0] exp_vec();
        int pos;
        pos = cur_pos();
        return {16'(pos % HT), 16'(pos / HT), m_rgb, m_hs, m_vs, m_de, m_ft};
    endfunction

    task automatic model_reset();
        m_clks = 0;
        m_rgb  = 8'h00;
        m_de   = 1'b0;
        m_hs   = 1'b1;
        m_vs   = 1'b1;
        m_ft   = 1'b0;
    endtask

    // One rising edge: on every PD-th clk the outputs show the pixel that was
    // being fetched during the previous pixel period.
    task automatic model_advance();
        int   k, prev, x, y;
        logic act;
        m_clks++;
        m_ft = 1'b0;
        if (m_clks % PD == 0) begin
            k    = m_clks / PD;
            prev = (k - 1) % FT;
            x    = prev % HT;
            y    = prev / HT;
            act  = (x < HA) && (y < VA);
            m_rgb = act ? pix_s : 8'h00;
            m_de  = act;
            m_hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
            m_vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
            m_ft  = (x == HT - 1) && (y == VA - 1);
        end
    endtask

    // Drive pixelIn at the falling edge, advance the model at the rising edge,
    // return 1 time unit later for sampling.
    task automatic clk_step(input logic [7:0] pix);
        @(negedge clk);
        pix_s = pix;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (obs_s !== exp_vec())
            $display("FAIL reset_state got=%h want=%h", obs_s, exp_vec());
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_step(8'h00);
            n_checks++;
            if (obs_s !== exp_vec())
                $display("FAIL reset_release clk=%0d got=%h want=%h", m_clks, obs_s, exp_vec());
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (nx_s !== 16'd1)
                    $display("FAIL first_step nextX got=%0d want=1", nx_s);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full_frame();
        int hs_low = 0;
        int vs_low = 0;
        for (int i = 0; i < FT * PD; i++) begin
            clk_step(8'((cur_pos() % HT)) ^ 8'hA0);
            n_checks++;
            if (obs_s !== exp_vec())
                $display("FAIL full_frame clk=%0d got=%h want=%h", m_clks, obs_s, exp_vec());
            else n_pass++;
            if (hs_s === 1'b0) hs_low++;
            if (vs_s === 1'b0) vs_low++;
        end
        n_checks++;
        if (hs_low != VT * HS * PD)
            $display("FAIL hsync_low_clks got=%0d want=%0d", hs_low, VT * HS * PD);
        else n_pass++;
        n_checks++;
        if (vs_low != VS * HT * PD)
            $display("FAIL vsync_low_clks got=%0d want=%0d", vs_low, VS * HT * PD);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int ft_cnt = 0;
        int ft_last = -1;
        int bad_gap = 0;
        for (int i = 0; i < 3 * FT * PD; i++) begin
            clk_step(8'($urandom));
            n_checks++;
            if (obs_s !== exp_vec())
                $display("FAIL wrap clk=%0d got=%h want=%h", m_clks, obs_s, exp_vec());
            else n_pass++;
            if (ft_s === 1'b1) begin
                if (ft_last >= 0 && (m_clks - ft_last) != FT * PD) bad_gap++;
                ft_last = m_clks;
                ft_cnt++;
            end
        end
        n_checks++;
        if (ft_cnt != 3)
            $display("FAIL frame_tick_count got=%0d want=3", ft_cnt);
        else n_pass++;
        n_checks++;
        if (bad_gap != 0)
            $display("FAIL frame_tick_spacing bad_gaps=%0d want=0", bad_gap);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int target;
        target = 2 * HT + 5;
        for (int i = 0; i < 2 * FT * PD && cur_pos() != target; i++) begin
            clk_step(8'($urandom));
            n_checks++;
            if (obs_s !== exp_vec())
                $display("FAIL pre_reset clk=%0d got=%h want=%h", m_clks, obs_s, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (nx_s !== 16'd5 || ny_s !== 16'd2)
            $display("FAIL reset_point got=(%0d,%0d) want=(5,2)", nx_s, ny_s);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_s !== exp_vec())
            $display("FAIL async_clear got=%h want=%h", obs_s, exp_vec());
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_s !== exp_vec())
            $display("FAIL reset_hold got=%h want=%h", obs_s, exp_vec());
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            clk_step(8'($urandom));
            n_checks++;
            if (obs_s !== exp_vec())
                $display("FAIL restart clk=%0d got=%h want=%h", m_clks, obs_s, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_pixel_toggle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pix_s = 8'($urandom);
            @(posedge clk);
            model_advance();
            #2;
            pix_s = ~pix_s;       // decoy value present only between edges
            n_checks++;
            if (obs_s !== exp_vec())
                $display("FAIL pixel_toggle clk=%0d got=%h want=%h", m_clks, obs_s, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_default_timing();
        int   n_clk = 2500;
        int   falls = 0;
        int   last_fall = -1;
        int   de_run = 0;
        int   bad_period = 0;
        int   bad_de = 0;
        int   vs_low = 0;
        int   bad_rgb = 0;
        logic prev_hs;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        prev_hs = hs_l;
        for (int c = 1; c <= n_clk; c++) begin
            clk_step(8'($urandom));
            if (de_l === 1'b1) de_run++;
            if (de_l === 1'b1 && rgb_l !== 8'h5A) bad_rgb++;
            if (vs_l !== 1'b1) vs_low++;
            if (prev_hs === 1'b1 && hs_l === 1'b0) begin
                if (last_fall >= 0) begin
                    if (c - last_fall != 800) bad_period++;
                    if (de_run != 640) bad_de++;
                end
                last_fall = c;
                de_run = 0;
                falls++;
            end
            prev_hs = hs_l;
        end
        n_checks++;
        if (falls != 3)
            $display("FAIL hsync_falls got=%0d want=3", falls);
        else n_pass++;
        n_checks++;
        if (bad_period != 0)
            $display("FAIL hsync_period bad=%0d want=0", bad_period);
        else n_pass++;
        n_checks++;
        if (bad_de != 0)
            $display("FAIL de_width bad=%0d want=0", bad_de);
        else n_pass++;
        n_checks++;
        if (vs_low != 0)
            $display("FAIL vsync_early low_clks=%0d want=0", vs_low);
        else n_pass++;
        n_checks++;
        if (bad_rgb != 0)
            $display("FAIL rgb_default bad=%0d want=0", bad_rgb);
        else n_pass++;
        n_checks++;
        if (nx_l !== 16'(n_clk % 800) || ny_l !== 16'(n_clk / 800))
            $display("FAIL default_coord got=(%0d,%0d) want=(%0d,%0d)",
                     nx_l, ny_l, n_clk % 800, n_clk / 800);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_wrap();
        test_async_reset();
        test_pixel_toggle();
        test_default_timing();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
